spi_accel_responder: RTL and testbench
======================================

Name: spi_accel_responder

Overview:
- SPI mode-0 responder (slave) that emulates one tri-axis accelerometer on the far end of the sensor SPI links. Used as the device model in system benches, and on a second board as a sensor stand-in.
- Decodes the sensor read/write command protocol, serves a register map, and returns X/Y/Z sample data that is snapshotted per transaction.
- SCK, CS_n and MOSI are oversampled in the clk domain; no logic is clocked by SCK.

Parameters:
- PART_ID, 8'hF2, value returned at address 0x01
- SYNC_STAGES, 2, synchronizer depth on sck/cs_n/mosi (min 2)
- MIN_SCK_HALF, 4, minimum SCK half-period in clk cycles that the block supports (documentation/assertion only)

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- sck  in  1  SPI clock from initiator, CPOL=0
- cs_n  in  1  SPI chip select, active-low
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- miso_oe  out  1  high while selected; top level tristates miso when low
- sample_x  in  16  X sample, two's complement
- sample_y  in  16  Y sample
- sample_z  in  16  Z sample
- sample_valid  in  1  one-cycle strobe that loads sample_x/y/z into the live registers
- cfg_power_ctl  out  8  current content of register 0x2D
- wr_strobe  out  1  one-cycle pulse per completed write byte
- wr_addr  out  8  address of that write
- wr_data  out  8  data of that write
- busy  out  1  transaction in progress (synced cs_n low)
- err_cmd  out  1  sticky; set on an illegal command byte, cleared by reset only

Behaviour:
- Reset values: miso=0, miso_oe=0, cfg_power_ctl=0, wr_*=0, busy=0, err_cmd=0. State=IDLE. All registers 0 except the constants.
- Sync: each input passes through SYNC_STAGES FFs plus one history FF. An SCK rise or fall is detected on the synced edge. Total latency from a pin edge to its internal action is SYNC_STAGES+1 clk.
- Register map (8-bit address):
  - 0x00 = 0xAD, RO
  - 0x01 = PART_ID, RO
  - 0x0B STATUS, RO; bit0 = DATA_READY
  - 0x0E..0x13 = X_L, X_H, Y_L, Y_H, Z_L, Z_H, RO, read from the shadow copy
  - 0x20..0x2F = RW bank; 0x2D is POWER_CTL
  - All other addresses read 0x00; writes to them are dropped.
- Commands: 0x0B = read, 0x0A = write. Any other value sets err_cmd, and the rest of the transaction is ignored.
- FSM states:
  - IDLE: on synced cs_n fall, copy live X/Y/Z to shadow, bit_cnt=0, miso_oe=1, miso=0, go to CMD.
  - CMD: shift 8 bits on SCK rise. After the 8th bit, go to ADDR, or to IGNORE if the command is illegal.
  - ADDR: shift 8 bits; after the 8th, latch the address.
    - Read: fetch tx_byte=reg[addr] on that same rise; go to RD.
    - Write: go to WR.
  - RD: on each SCK fall, drive miso from tx_byte MSB-first. The first fall after the address byte drives bit7. After 8 falls, addr=addr+1 (wraps 0xFF→0x00) and tx_byte=reg[addr] is reloaded before the next fall.
  - WR: shift 8 bits on rise. After the 8th, write reg[addr] if it is writable, pulse wr_strobe for 1 clk with wr_addr/wr_data, then addr+1 with wrap.
  - IGNORE: miso=0 until cs_n rises.
- Any state, synced cs_n rise: go to IDLE, miso_oe=0, miso=0, discard any partial byte (no write, no increment).
- Bits sampled on SCK rise: MOSI. Bits driven on SCK fall: MISO. In CMD/ADDR/WR, miso=0.
- DATA_READY:
  - Set by sample_valid.
  - Cleared at cs_n rise if the transaction read any byte in 0x0E..0x13.
  - Set wins if both happen in the same cycle.
- sample_valid during a transaction updates the live registers only; the shadow stays frozen, so X/Y/Z are always coherent within one burst.
- cs_n low with no SCK edges: nothing happens. SCK edges while cs_n is high: ignored.

Decomposition:
- Package spi_accel_pkg holds:
  - command constants (CMD_RD=8'h0B, CMD_WR=8'h0A)
  - register address localparams
  - DEVID constant 8'hAD
  - FSM state enum
- Sub-module spi_in_sync: synchronizer plus edge detect for the three pins. Outputs sck_rise, sck_fall, cs_fall, cs_rise, mosi_s.

Test Plan:
- Read DEVID: cs_n low, send 0x0B 0x00, clock 8 more bits at SCK 10 MHz → miso shifts 0xAD, err_cmd=0.
- Burst axes: sample_valid with x=0x0123, y=0xFF80, z=0x4000, then read 6 bytes from 0x0E → 23 01 80 FF 00 40, and STATUS bit0 reads 0 in the next transaction.
- Coherency: assert sample_valid with x=0x7FFF between byte 1 and byte 2 of the burst above → burst still returns 23 01; the next burst returns FF 7F.
- Write/readback: send 0x0A 0x2D 0x02 → wr_strobe once with addr 0x2D, data 0x02; cfg_power_ctl=0x02; reading 0x2D returns 0x02. A write to 0x00 is dropped.
- Abort and wrap:
  - cs_n rises after 5 bits of a write data byte → no wr_strobe, register unchanged.
  - Read from 0xFF, 2 bytes → returns 00 then AD (wrap to 0x00).
- Illegal command and reset: command 0x55 → err_cmd=1, miso=0 until cs_n rises. Assert reset_n low mid-read → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/spi_accel_pkg.sv
// rtl/spi_accel_pkg.sv - Command codes, register addresses and FSM states for the accelerometer responder
package spi_accel_pkg;

  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] DEVID  = 8'hAD;

  localparam logic [7:0] ADDR_DEVID     = 8'h00;
  localparam logic [7:0] ADDR_PART_ID   = 8'h01;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_X_L       = 8'h0E;
  localparam logic [7:0] ADDR_X_H       = 8'h0F;
  localparam logic [7:0] ADDR_Y_L       = 8'h10;
  localparam logic [7:0] ADDR_Y_H       = 8'h11;
  localparam logic [7:0] ADDR_Z_L       = 8'h12;
  localparam logic [7:0] ADDR_Z_H       = 8'h13;
  localparam logic [7:0] ADDR_BANK_LO   = 8'h20;
  localparam logic [7:0] ADDR_BANK_HI   = 8'h2F;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - Synchronizes sck/cs_n/mosi into clk and detects sck and cs_n edges
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s,
  output logic cs_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_hist;
  logic                   r_cs_hist;
  logic                   w_sck_s;

  // cs_n resets high so leaving reset never looks like a select
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_hist  <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_hist  <= w_sck_s;
      r_cs_hist   <= cs_s;
    end
  end

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign sck_rise = w_sck_s & ~r_sck_hist;
  assign sck_fall = ~w_sck_s & r_sck_hist;
  assign cs_fall  = ~cs_s & r_cs_hist;
  assign cs_rise  = cs_s & ~r_cs_hist;

endmodule

// File: rtl/spi_accel_responder.sv
// rtl/spi_accel_responder.sv - SPI mode-0 tri-axis accelerometer responder with register map and sample snapshots
module spi_accel_responder #(
  parameter logic [7:0] PART_ID      = 8'hF2,
  parameter int         SYNC_STAGES  = 2,
  parameter int         MIN_SCK_HALF = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  cfg_power_ctl,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        err_cmd
);
  import spi_accel_pkg::*;

  if (SYNC_STAGES < 2 || MIN_SCK_HALF < 2) begin : g_param_check
    $error("spi_accel_responder needs SYNC_STAGES >= 2 and MIN_SCK_HALF >= 2");
  end

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_mosi_s, w_cs_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sck_rise (w_sck_rise),
    .sck_fall (w_sck_fall),
    .cs_fall  (w_cs_fall),
    .cs_rise  (w_cs_rise),
    .mosi_s   (w_mosi_s),
    .cs_s     (w_cs_s)
  );

  state_t      r_state, w_next_state;
  logic [6:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_cmd_wr;
  logic [7:0]  r_addr;
  logic [7:0]  r_tx_byte;
  logic        r_miso, r_miso_oe;
  logic        r_axis_read;
  logic        r_err_cmd;
  logic        r_wr_strobe;
  logic [7:0]  r_wr_addr, r_wr_data;
  logic [15:0] r_live_x, r_live_y, r_live_z;
  logic [15:0] r_shadow_x, r_shadow_y, r_shadow_z;
  logic        r_data_ready;
  logic [7:0]  r_bank [16];

  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic [7:0]  w_addr_next;

  assign w_byte      = {r_shift, w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_addr_next = r_addr + 8'd1;

  function automatic logic is_writable(input logic [7:0] a);
    return (a >= ADDR_BANK_LO) && (a <= ADDR_BANK_HI);
  endfunction

  function automatic logic is_axis(input logic [7:0] a);
    return (a >= ADDR_X_L) && (a <= ADDR_Z_H);
  endfunction

  // Axis bytes always come from the shadow so a burst is coherent
  function automatic logic [7:0] reg_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      ADDR_DEVID:   v = DEVID;
      ADDR_PART_ID: v = PART_ID;
      ADDR_STATUS:  v = {7'd0, r_data_ready};
      ADDR_X_L:     v = r_shadow_x[7:0];
      ADDR_X_H:     v = r_shadow_x[15:8];
      ADDR_Y_L:     v = r_shadow_y[7:0];
      ADDR_Y_H:     v = r_shadow_y[15:8];
      ADDR_Z_L:     v = r_shadow_z[7:0];
      ADDR_Z_H:     v = r_shadow_z[15:8];
      default:      if (is_writable(a)) v = r_bank[a[3:0]];
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cs_rise) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_next_state = ST_CMD;
        ST_CMD: begin
          if (w_byte_done) begin
            if (w_byte == CMD_RD || w_byte == CMD_WR) w_next_state = ST_ADDR;
            else                                      w_next_state = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (w_byte_done) begin
            if (r_cmd_wr) w_next_state = ST_WR;
            else          w_next_state = ST_RD;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cmd_wr     <= 1'b0;
      r_addr       <= '0;
      r_tx_byte    <= '0;
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_axis_read  <= 1'b0;
      r_err_cmd    <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_live_x     <= '0;
      r_live_y     <= '0;
      r_live_z     <= '0;
      r_shadow_x   <= '0;
      r_shadow_y   <= '0;
      r_shadow_z   <= '0;
      r_data_ready <= 1'b0;
      for (int i = 0; i < 16; i++) r_bank[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (sample_valid) begin
        r_live_x <= sample_x;
        r_live_y <= sample_y;
        r_live_z <= sample_z;
      end
      // A new sample in the same cycle as the clearing cs_n rise keeps DATA_READY set
      if (sample_valid)                   r_data_ready <= 1'b1;
      else if (w_cs_rise && r_axis_read)  r_data_ready <= 1'b0;

      if (w_cs_rise) begin
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_shadow_x  <= r_live_x;
              r_shadow_y  <= r_live_y;
              r_shadow_z  <= r_live_z;
              r_bit_cnt   <= '0;
              r_miso_oe   <= 1'b1;
              r_miso      <= 1'b0;
              r_axis_read <= 1'b0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                if (w_byte == CMD_WR)      r_cmd_wr  <= 1'b1;
                else if (w_byte == CMD_RD) r_cmd_wr  <= 1'b0;
                else                       r_err_cmd <= 1'b1;
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_addr    <= w_byte;
                r_tx_byte <= reg_read(w_byte);
              end
            end
          end
          ST_WR: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                if (is_writable(r_addr)) r_bank[r_addr[3:0]] <= w_byte;
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_byte;
                r_addr      <= w_addr_next;
              end
            end
          end
          ST_RD: begin
            // The 8th fall puts bit0 out and preloads the next byte for the following fall
            if (w_sck_fall) begin
              r_miso    <= r_tx_byte[7];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (is_axis(r_addr)) r_axis_read <= 1'b1;
                r_addr    <= w_addr_next;
                r_tx_byte <= reg_read(w_addr_next);
              end else begin
                r_tx_byte <= {r_tx_byte[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign miso          = r_miso;
  assign miso_oe       = r_miso_oe;
  assign cfg_power_ctl = r_bank[ADDR_POWER_CTL[3:0]];
  assign wr_strobe     = r_wr_strobe;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign busy          = ~w_cs_s;
  assign err_cmd       = r_err_cmd;

endmodule

// File: tb/tb_spi_accel_responder.sv
// tb/tb_spi_accel_responder.sv - Scoreboard bench for spi_accel_responder with a register-map reference model
module tb_spi_accel_responder;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        reset_n, sck, cs_n, mosi;
  logic        miso, miso_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic [7:0]  cfg_power_ctl;
  logic        wr_strobe;
  logic [7:0]  wr_addr, wr_data;
  logic        busy, err_cmd;

  always #5 clk = ~clk;

  spi_accel_responder #(.PART_ID(8'hF2), .SYNC_STAGES(2), .MIN_SCK_HALF(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sck           (sck),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso),
    .miso_oe       (miso_oe),
    .sample_x      (sample_x),
    .sample_y      (sample_y),
    .sample_z      (sample_z),
    .sample_valid  (sample_valid),
    .cfg_power_ctl (cfg_power_ctl),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .err_cmd       (err_cmd)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  ref_bank [256];
  logic [15:0] ref_live [3];
  logic [15:0] ref_shadow [3];
  logic        ref_dr;
  logic        txn_axis;
  logic [7:0]  cur_addr;
  logic [7:0]  exp_rd_q [$];
  logic [15:0] exp_wr_q [$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_bank[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      ref_live[i]   = 16'h0;
      ref_shadow[i] = 16'h0;
    end
    ref_dr = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'hF2;
      8'h0B: return {7'd0, ref_dr};
      8'h0E: return ref_shadow[0][7:0];
      8'h0F: return ref_shadow[0][15:8];
      8'h10: return ref_shadow[1][7:0];
      8'h11: return ref_shadow[1][15:8];
      8'h12: return ref_shadow[2][7:0];
      8'h13: return ref_shadow[2][15:8];
      default: return (a >= 8'h20 && a <= 8'h2F) ? ref_bank[a] : 8'h00;
    endcase
  endfunction

  // Bus monitor: decodes the command from mosi and scores every full read data byte
  logic [7:0] mon_mosi, mon_miso, mon_cmd, mon_last_miso;
  int         mon_bits, mon_idx;

  always @(negedge cs_n) begin
    mon_bits = 0;
    mon_idx  = 0;
  end

  always @(posedge sck) begin : rd_mon
    logic [7:0] e;
    if (cs_n === 1'b0) begin
      mon_mosi = {mon_mosi[6:0], mosi};
      mon_miso = {mon_miso[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits      = 0;
        mon_last_miso = mon_miso;
        if (mon_idx == 0) begin
          mon_cmd = mon_mosi;
        end else if (mon_idx >= 2 && mon_cmd == 8'h0B) begin
          if (exp_rd_q.size() == 0) begin
            n_total++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no read byte", mon_miso);
          end else begin
            e = exp_rd_q.pop_front();
            check("rd_byte", {8'h00, mon_miso}, {8'h00, e});
          end
        end
        mon_idx++;
      end
    end
  end

  always @(negedge clk) begin : wr_mon
    logic [15:0] e;
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", {8'h00, wr_addr}, {8'h00, e[15:8]});
        check("wr_data", {8'h00, wr_data}, {8'h00, e[7:0]});
      end
    end
  end

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    ref_live[0] = x;
    ref_live[1] = y;
    ref_live[2] = z;
    ref_dr = 1'b1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      #(HALF);
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_begin();
    ref_shadow = ref_live;
    txn_axis   = 1'b0;
    cs_n       = 1'b0;
    #(HALF);
  endtask

  task automatic spi_end();
    #(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    if (txn_axis) ref_dr = 1'b0;
    #(HALF * 4);
  endtask

  task automatic rd_byte();
    exp_rd_q.push_back(model_read(cur_addr));
    if (cur_addr >= 8'h0E && cur_addr <= 8'h13) txn_axis = 1'b1;
    spi_bits(8'h00, 8);
    cur_addr = cur_addr + 8'd1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    exp_wr_q.push_back({cur_addr, d});
    if (cur_addr >= 8'h20 && cur_addr <= 8'h2F) ref_bank[cur_addr] = d;
    spi_bits(d, 8);
    cur_addr = cur_addr + 8'd1;
  endtask

  task automatic open_cmd(input logic [7:0] cmd, input logic [7:0] a);
    spi_begin();
    spi_bits(cmd, 8);
    spi_bits(a, 8);
    cur_addr = a;
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    open_cmd(8'h0B, a);
    repeat (n) rd_byte();
    spi_end();
  endtask

  task automatic spi_write1(input logic [7:0] a, input logic [7:0] d);
    open_cmd(8'h0A, a);
    wr_byte(d);
    spi_end();
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(8'h0B, 8'h13));
      2:       return 8'($urandom_range(8'h1E, 8'h31));
      default: return 8'($urandom_range(8'hFC, 8'hFF));
    endcase
  endfunction

  initial begin
    #(800000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    int         n;
    reset_n = 1'b0;
    cs_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    sample_x = '0;
    sample_y = '0;
    sample_z = '0;
    sample_valid = 1'b0;
    mon_mosi = '0;
    mon_miso = '0;
    mon_cmd = '0;
    mon_last_miso = '0;
    mon_bits = 0;
    mon_idx = 0;
    model_reset();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_miso", {15'd0, miso}, 16'h0);
    check("rst_miso_oe", {15'd0, miso_oe}, 16'h0);
    check("rst_cfg", {8'd0, cfg_power_ctl}, 16'h0);
    check("rst_wr", {7'd0, wr_strobe, wr_addr | wr_data}, 16'h0);
    check("rst_busy_err", {14'd0, busy, err_cmd}, 16'h0);

    spi_read(8'h00, 2);
    check("err_after_read", {15'd0, err_cmd}, 16'h0);

    pulse_sample(16'h0123, 16'hFF80, 16'h4000);
    spi_read(8'h0B, 1);
    spi_read(8'h0E, 6);
    open_cmd(8'h0B, 8'h0B);
    check("busy_in_txn", {15'd0, busy}, 16'h1);
    rd_byte();
    spi_end();

    pulse_sample(16'h0123, 16'hFF80, 16'h4000);
    open_cmd(8'h0B, 8'h0E);
    rd_byte();
    pulse_sample(16'h7FFF, 16'hFF80, 16'h4000);
    rd_byte();
    spi_end();
    spi_read(8'h0E, 2);
    spi_read(8'h0B, 1);

    spi_write1(8'h2D, 8'h02);
    check("cfg_after_write", {8'd0, cfg_power_ctl}, 16'h0002);
    spi_read(8'h2D, 1);
    spi_write1(8'h00, 8'h55);
    spi_read(8'h00, 1);

    spi_write1(8'h21, 8'h11);
    open_cmd(8'h0A, 8'h21);
    spi_bits(8'hEE, 5);
    spi_end();
    spi_read(8'h21, 1);
    spi_read(8'hFF, 2);

    spi_begin();
    spi_bits(8'h55, 8);
    spi_bits(8'hFF, 8);
    check("err_cmd_set", {15'd0, err_cmd}, 16'h1);
    check("ignore_miso_byte", {8'd0, mon_last_miso}, 16'h0);
    check("ignore_miso_oe", {14'd0, miso_oe, miso}, 16'h2);
    spi_end();
    check("err_cmd_sticky", {15'd0, err_cmd}, 16'h1);

    open_cmd(8'h0B, 8'h2D);
    spi_bits(8'h00, 4);
    check("pre_reset_busy", {15'd0, busy}, 16'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_miso", {14'd0, miso_oe, miso}, 16'h0);
    check("mid_rst_cfg", {8'd0, cfg_power_ctl}, 16'h0);
    check("mid_rst_wr", {7'd0, wr_strobe, wr_addr | wr_data}, 16'h0);
    check("mid_rst_busy_err", {14'd0, busy, err_cmd}, 16'h0);
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          a = pick_addr();
          n = $urandom_range(1, 4);
          spi_read(a, n);
        end
        2: begin
          a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8'h1E, 8'h31));
          n = $urandom_range(1, 3);
          open_cmd(8'h0A, a);
          repeat (n) wr_byte(8'($urandom));
          spi_end();
        end
        default: begin
          a = 8'($urandom_range(8'h20, 8'h2F));
          n = $urandom_range(0, 2);
          open_cmd(8'h0A, a);
          repeat (n) wr_byte(8'($urandom));
          spi_bits(8'($urandom), $urandom_range(1, 7));
          spi_end();
        end
      endcase
      check("cfg_track", {8'd0, cfg_power_ctl}, {8'd0, ref_bank[8'h2D]});
    end

    repeat (10) @(negedge clk);
    check("rd_queue_drained", 16'(exp_rd_q.size()), 16'h0);
    check("wr_queue_drained", 16'(exp_wr_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
